// File: rtl/uart_axis_pkg.sv
// Shared definitions for the UART TX stream arbiter.
package uart_axis_pkg;

  localparam int AXIS_DATA_W = 32;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first requester strictly after ptr, wrapping.
// Purely combinational; the caller owns the pointer register.
module rr_pick #(
  parameter int N_REQ = 3
) (
  input  logic [N_REQ-1:0]         req,
  input  logic [$clog2(N_REQ)-1:0] ptr,
  output logic [N_REQ-1:0]         gnt,
  output logic [$clog2(N_REQ)-1:0] idx
);

  localparam int IDX_W = $clog2(N_REQ);

  // Scan the sources in rotated order starting one past the pointer.
  always_comb begin
    int               k;
    logic             found;
    logic [IDX_W-1:0] kk;
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    k     = 0;
    kk    = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      k  = (int'(ptr) + i) % N_REQ;
      kk = IDX_W'(k);
      if (!found && req[kk]) begin
        found   = 1'b1;
        gnt[kk] = 1'b1;
        idx     = kk;
      end
    end
  end

endmodule

// File: rtl/uart_axis_arbiter.sv
// Packet-level round-robin arbiter merging N_REQ AXI-Stream sources onto
// the single UART TX stream, with a mid-packet stall timeout.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | no owner; picks next requester after ptr, no beat passes
// LOCKED | grant held by gidx until tlast beat or stall timeout
module uart_axis_arbiter
  import uart_axis_pkg::*;
#(
  parameter int N_REQ       = 3,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                         clk_i,
  input  logic                         reset_ni,
  input  logic [N_REQ-1:0]             s_valid_i,
  input  logic [N_REQ*AXIS_DATA_W-1:0] s_data_i,
  input  logic [N_REQ-1:0]             s_last_i,
  output logic [N_REQ-1:0]             s_ready_o,
  output logic                         m_valid_o,
  output logic [AXIS_DATA_W-1:0]       m_data_o,
  output logic                         m_last_o,
  input  logic                         m_ready_i,
  output logic [N_REQ-1:0]             grant_o,
  output logic                         timeout_err_o,
  input  logic                         err_clr_i
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam int CNT_W = $clog2(TIMEOUT_CYC) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [IDX_W-1:0] PTR_RST = IDX_W'(N_REQ - 1);

  arb_state_e       state_q, state_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [IDX_W-1:0] gidx_q, gidx_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  logic [N_REQ-1:0]       pick_gnt;
  logic [IDX_W-1:0]       pick_idx;
  logic                   sel_valid;
  logic                   sel_last;
  logic [AXIS_DATA_W-1:0] sel_data;
  logic                   locked;
  logic                   xfer;

  rr_pick #(
    .N_REQ(N_REQ)
  ) u_rr_pick (
    .req(s_valid_i),
    .ptr(ptr_q),
    .gnt(pick_gnt),
    .idx(pick_idx)
  );

  assign locked = (state_q == LOCKED);
  assign xfer   = m_valid_o & m_ready_i;

  // Select the granted source's stream signals.
  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gidx_q == IDX_W'(i)) begin
        sel_valid = s_valid_i[i];
        sel_last  = s_last_i[i];
        sel_data  = s_data_i[i*AXIS_DATA_W +: AXIS_DATA_W];
      end
    end
  end

  // Zero-latency pass-through while locked; everything quiet otherwise.
  always_comb begin
    m_valid_o = locked & sel_valid;
    m_last_o  = locked & sel_last;
    m_data_o  = locked ? sel_data : '0;
    s_ready_o = locked ? (grant_q & {N_REQ{m_ready_i}}) : '0;
  end

  // Next-state, grant, pointer, stall counter and sticky error.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    gidx_d  = gidx_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    if (err_clr_i) begin
      err_d = 1'b0;
    end
    case (state_q)
      IDLE: begin
        if (|s_valid_i) begin
          state_d = LOCKED;
          grant_d = pick_gnt;
          gidx_d  = pick_idx;
          cnt_d   = '0;
        end
      end
      LOCKED: begin
        if (xfer && m_last_o) begin
          state_d = IDLE;
          grant_d = '0;
          ptr_d   = gidx_q;
          cnt_d   = '0;
        end else if (sel_valid) begin
          cnt_d = '0;
        end else if (cnt_q >= CNT_MAX) begin
          // Source stalled too long: drop it without inventing a tlast.
          state_d = IDLE;
          grant_d = '0;
          ptr_d   = gidx_q;
          cnt_d   = '0;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= IDLE;
      grant_q <= '0;
      gidx_q  <= '0;
      ptr_q   <= PTR_RST;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      gidx_q  <= gidx_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign grant_o       = grant_q;
  assign timeout_err_o = err_q;

endmodule

// File: tb/tb_uart_axis_arbiter.sv
// Directed bench for uart_axis_arbiter (N_REQ=3, TIMEOUT_CYC=8).
module tb_uart_axis_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  s_valid;
  logic [95:0] s_data;
  logic [2:0]  s_last;
  logic [2:0]  s_ready;
  logic        m_valid;
  logic [31:0] m_data;
  logic        m_last;
  logic        m_ready;
  logic [2:0]  grant;
  logic        err;
  logic        err_clr;

  int tests = 0;
  int fails = 0;
  int g;
  int b;

  always #20 clk = ~clk;

  uart_axis_arbiter #(
    .N_REQ(3),
    .TIMEOUT_CYC(8)
  ) dut (
    .clk_i(clk),
    .reset_ni(rst_n),
    .s_valid_i(s_valid),
    .s_data_i(s_data),
    .s_last_i(s_last),
    .s_ready_o(s_ready),
    .m_valid_o(m_valid),
    .m_data_o(m_data),
    .m_last_o(m_last),
    .m_ready_i(m_ready),
    .grant_o(grant),
    .timeout_err_o(err),
    .err_clr_i(err_clr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_all(input int beat, input logic [2:0] last);
    for (int k = 0; k < 3; k++) begin
      s_data[k*32 +: 32] = 32'hD000_0000 + 32'(k * 256 + beat);
    end
    s_last = last;
  endtask

  initial begin
    rst_n   = 1'b0;
    s_valid = 3'b111;
    s_data  = '0;
    s_last  = 3'b000;
    m_ready = 1'b1;
    err_clr = 1'b0;
    drive_all(0, 3'b000);

    // Held in reset with all sources requesting.
    repeat (2) step();
    #5;
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_mvalid", 32'(m_valid), 32'h0);
    chk("rst_mlast", 32'(m_last), 32'h0);
    chk("rst_sready", 32'(s_ready), 32'h0);
    chk("rst_mdata", m_data, 32'h0);
    chk("rst_err", 32'(err), 32'h0);

    // First cycle after release stays quiet.
    step();
    rst_n = 1'b1;
    #5;
    chk("rel_grant", 32'(grant), 32'h0);
    chk("rel_mvalid", 32'(m_valid), 32'h0);
    chk("rel_sready", 32'(s_ready), 32'h0);
    chk("rel_mdata", m_data, 32'h0);

    // Three sources, continuous 2-beat packets: order 0,1,2,0 with one bubble.
    for (int p = 0; p < 4; p++) begin
      g = p % 3;
      step();
      drive_all(0, 3'b000);
      #5;
      chk("rr_grant_b0", 32'(grant), 32'(1 << g));
      chk("rr_mvalid_b0", 32'(m_valid), 32'h1);
      chk("rr_mdata_b0", m_data, 32'hD000_0000 + 32'(g * 256));
      chk("rr_mlast_b0", 32'(m_last), 32'h0);
      chk("rr_sready_b0", 32'(s_ready), 32'(1 << g));
      step();
      drive_all(1, 3'b111);
      #5;
      chk("rr_grant_b1", 32'(grant), 32'(1 << g));
      chk("rr_mdata_b1", m_data, 32'hD000_0000 + 32'(g * 256 + 1));
      chk("rr_mlast_b1", 32'(m_last), 32'h1);
      step();
      drive_all(0, 3'b000);
      if (p == 3) s_valid = 3'b000;
      #5;
      chk("rr_bubble_grant", 32'(grant), 32'h0);
      chk("rr_bubble_mvalid", 32'(m_valid), 32'h0);
    end

    // Source 1 streams 4 beats under toggling ready; source 2 holds tlast.
    step();
    s_valid = 3'b110;
    s_last  = 3'b100;
    s_data[63:32] = 32'hE100_0000;
    s_data[95:64] = 32'hE200_0000;
    #5;
    chk("idle_no_xfer_grant", 32'(grant), 32'h0);
    chk("idle_no_xfer_mvalid", 32'(m_valid), 32'h0);
    chk("idle_no_xfer_sready", 32'(s_ready), 32'h0);
    for (int c = 0; c < 7; c++) begin
      step();
      b = (c + 1) / 2;
      m_ready = (c % 2 == 0);
      s_data[63:32] = 32'hE100_0000 + 32'(b);
      s_data[95:64] = 32'hE200_0000 + 32'(c);
      s_last = {1'b1, (b == 3), 1'b0};
      #5;
      chk("bp_grant", 32'(grant), 32'h2);
      chk("bp_mdata", m_data, 32'hE100_0000 + 32'(b));
      chk("bp_mlast", 32'(m_last), 32'((b == 3) ? 1 : 0));
      chk("bp_sready", 32'(s_ready), m_ready ? 32'h2 : 32'h0);
    end
    step();
    s_valid = 3'b000;
    s_last  = 3'b000;
    m_ready = 1'b1;
    #5;
    chk("bp_done_grant", 32'(grant), 32'h0);

    // Source 0 sends one beat, stalls; source 1 waits meanwhile.
    step();
    s_valid = 3'b001;
    s_data[31:0] = 32'hF000_0000;
    #5;
    chk("to_idle_grant", 32'(grant), 32'h0);
    step();
    #5;
    chk("to_beat_grant", 32'(grant), 32'h1);
    chk("to_beat_mdata", m_data, 32'hF000_0000);
    chk("to_beat_mvalid", 32'(m_valid), 32'h1);
    step();
    s_valid = 3'b010;
    s_data[63:32] = 32'h1111_0001;
    s_last = 3'b010;
    #5;
    chk("to_stall_grant", 32'(grant), 32'h1);
    chk("to_stall_mvalid", 32'(m_valid), 32'h0);
    chk("to_stall_sready", 32'(s_ready), 32'h1);
    for (int k = 0; k < 7; k++) begin
      step();
      #5;
      chk("to_hold_grant", 32'(grant), 32'h1);
      chk("to_hold_err", 32'(err), 32'h0);
    end
    step();
    #5;
    chk("to_revoke_grant", 32'(grant), 32'h0);
    chk("to_revoke_err", 32'(err), 32'h1);
    chk("to_revoke_mvalid", 32'(m_valid), 32'h0);
    step();
    #5;
    chk("to_next_grant", 32'(grant), 32'h2);
    chk("to_next_mdata", m_data, 32'h1111_0001);
    chk("to_next_mlast", 32'(m_last), 32'h1);

    // Clear pulse, then a clear pulse coincident with a fresh timeout.
    step();
    s_valid = 3'b000;
    s_last  = 3'b000;
    err_clr = 1'b1;
    #5;
    chk("clr_pre_err", 32'(err), 32'h1);
    step();
    err_clr = 1'b0;
    s_valid = 3'b100;
    s_data[95:64] = 32'h2222_0000;
    #5;
    chk("clr_err", 32'(err), 32'h0);
    step();
    s_valid = 3'b000;
    #5;
    chk("to2_grant", 32'(grant), 32'h4);
    chk("to2_mvalid", 32'(m_valid), 32'h0);
    for (int k = 0; k < 6; k++) begin
      step();
      #5;
      chk("to2_hold_grant", 32'(grant), 32'h4);
    end
    step();
    err_clr = 1'b1;
    #5;
    chk("to2_last_grant", 32'(grant), 32'h4);
    chk("to2_last_err", 32'(err), 32'h0);
    step();
    err_clr = 1'b0;
    #5;
    chk("set_wins_err", 32'(err), 32'h1);
    chk("set_wins_grant", 32'(grant), 32'h0);

    // Reset asserted during beat 2 of a 4-beat packet.
    s_valid = 3'b001;
    s_data[31:0] = 32'hC000_0000;
    s_last = 3'b000;
    step();
    #5;
    chk("mr_b0_grant", 32'(grant), 32'h1);
    chk("mr_b0_mdata", m_data, 32'hC000_0000);
    step();
    s_data[31:0] = 32'hC000_0001;
    #5;
    chk("mr_b1_mdata", m_data, 32'hC000_0001);
    chk("mr_b1_mvalid", 32'(m_valid), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("mr_rst_mvalid", 32'(m_valid), 32'h0);
    chk("mr_rst_mdata", m_data, 32'h0);
    chk("mr_rst_grant", 32'(grant), 32'h0);
    chk("mr_rst_sready", 32'(s_ready), 32'h0);
    chk("mr_rst_mlast", 32'(m_last), 32'h0);
    chk("mr_rst_err", 32'(err), 32'h0);
    step();
    rst_n = 1'b1;
    #5;
    chk("mr_rel_grant", 32'(grant), 32'h0);
    chk("mr_rel_mvalid", 32'(m_valid), 32'h0);
    chk("mr_rel_mdata", m_data, 32'h0);
    step();
    s_data[31:0] = 32'hC000_0000;
    #5;
    chk("mr_fresh_grant", 32'(grant), 32'h1);
    chk("mr_fresh_mdata", m_data, 32'hC000_0000);
    s_valid = 3'b000;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
